issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl.sv | 110 +++++++++++
 tb/tb_issue_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - dual-issue decode gate with load scoreboard and divider occupancy FSM
module issue_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] s0_rs_addr,
  input  logic [4:0] s0_rt_addr,
  input  logic [4:0] s1_rs_addr,
  input  logic [4:0] s1_rt_addr,
  input  logic       s0_rs_en,
  input  logic       s0_rt_en,
  input  logic       s1_rs_en,
  input  logic       s1_rt_en,
  input  logic       s0_wen,
  input  logic       s1_wen,
  input  logic [4:0] s0_waddr,
  input  logic [4:0] s1_waddr,
  input  logic       s0_is_load,
  input  logic       s1_is_load,
  input  logic       s0_is_div,
  input  logic       s1_is_div,
  input  logic       s0_hilo_rd,
  input  logic       s1_hilo_rd,
  input  logic       s1_valid,
  input  logic       mem_stall,
  input  logic       flush,
  output logic       issue0,
  output logic       issue1,
  output logic       div_busy
);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  div_state_t  div_state;
  logic [4:0]  div_cnt;
  logic [1:0]  cd [32];
  logic [31:0] pend;
  logic        s0_haz, s1_haz, s1_raw, ld_set0, ld_set1;

  // cd[0] is never loaded, so pend[0] stays 0 and $0 never hazards
  always_comb begin
    pend = '0;
    for (int r = 0; r < 32; r++) pend[r] = (cd[r] != 2'd0);
  end

  assign s0_haz = (s0_rs_en & pend[s0_rs_addr]) | (s0_rt_en & pend[s0_rt_addr]);
  assign s1_haz = (s1_rs_en & pend[s1_rs_addr]) | (s1_rt_en & pend[s1_rt_addr]);
  assign s1_raw = s0_wen & (s0_waddr != 5'd0) &
                  ((s1_rs_en & (s1_rs_addr == s0_waddr)) | (s1_rt_en & (s1_rt_addr == s0_waddr)));

  assign issue0 = !rst & id_valid & !mem_stall & !flush & !s0_haz &
                  !(s0_is_div & div_busy) & !(s0_hilo_rd & div_busy);
  assign issue1 = issue0 & s1_valid & !s1_is_div & !s1_haz & !(s1_hilo_rd & div_busy) &
                  !s1_raw & !(s0_is_load & s1_is_load) & !(s0_is_div & s1_hilo_rd);

  assign ld_set0 = issue0 & s0_is_load & s0_wen & (s0_waddr != 5'd0);
  assign ld_set1 = issue1 & s1_is_load & s1_wen & (s1_waddr != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) cd[r] <= 2'd0;
    end else if (flush) begin
      for (int r = 0; r < 32; r++) cd[r] <= 2'd0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if ((ld_set0 && s0_waddr == 5'(r)) || (ld_set1 && s1_waddr == 5'(r)))
          cd[r] <= 2'd2;
        else if (!mem_stall && cd[r] != 2'd0)
          cd[r] <= cd[r] - 2'd1;
      end
    end
  end

  // Divider runs off the pipeline clock only; mem_stall does not pause it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_state <= DIV_IDLE;
      div_cnt   <= 5'd0;
      div_busy  <= 1'b0;
    end else if (flush) begin
      div_state <= DIV_IDLE;
      div_cnt   <= 5'd0;
      div_busy  <= 1'b0;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (issue0 && s0_is_div) begin
            div_state <= DIV_BUSY;
            div_cnt   <= 5'd31;
            div_busy  <= 1'b1;
          end
        end
        DIV_BUSY: begin
          if (div_cnt == 5'd0) div_state <= DIV_DONE;
          else                 div_cnt   <= div_cnt - 5'd1;
          div_busy <= 1'b1;
        end
        DIV_DONE: begin
          div_state <= DIV_IDLE;
          div_busy  <= 1'b0;
        end
        default: begin
          div_state <= DIV_IDLE;
          div_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - directed-vector bench for issue_ctrl
module tb_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] s0_rs_addr, s0_rt_addr, s1_rs_addr, s1_rt_addr;
  logic       s0_rs_en, s0_rt_en, s1_rs_en, s1_rt_en;
  logic       s0_wen, s1_wen;
  logic [4:0] s0_waddr, s1_waddr;
  logic       s0_is_load, s1_is_load, s0_is_div, s1_is_div, s0_hilo_rd, s1_hilo_rd;
  logic       s1_valid, mem_stall, flush;
  logic       issue0, issue1, div_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  issue_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .s0_rs_addr(s0_rs_addr), .s0_rt_addr(s0_rt_addr),
    .s1_rs_addr(s1_rs_addr), .s1_rt_addr(s1_rt_addr),
    .s0_rs_en(s0_rs_en), .s0_rt_en(s0_rt_en), .s1_rs_en(s1_rs_en), .s1_rt_en(s1_rt_en),
    .s0_wen(s0_wen), .s1_wen(s1_wen), .s0_waddr(s0_waddr), .s1_waddr(s1_waddr),
    .s0_is_load(s0_is_load), .s1_is_load(s1_is_load),
    .s0_is_div(s0_is_div), .s1_is_div(s1_is_div),
    .s0_hilo_rd(s0_hilo_rd), .s1_hilo_rd(s1_hilo_rd),
    .s1_valid(s1_valid), .mem_stall(mem_stall), .flush(flush),
    .issue0(issue0), .issue1(issue1), .div_busy(div_busy)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clr();
    id_valid = 0; s1_valid = 0; mem_stall = 0; flush = 0;
    s0_rs_addr = 0; s0_rt_addr = 0; s1_rs_addr = 0; s1_rt_addr = 0;
    s0_rs_en = 0; s0_rt_en = 0; s1_rs_en = 0; s1_rt_en = 0;
    s0_wen = 0; s1_wen = 0; s0_waddr = 0; s1_waddr = 0;
    s0_is_load = 0; s1_is_load = 0; s0_is_div = 0; s1_is_div = 0;
    s0_hilo_rd = 0; s1_hilo_rd = 0;
  endtask

  // Advance to the next cycle: inputs are driven 1ns after the edge, checks made at +4
  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle(input int n);
    clr();
    for (int i = 0; i < n; i++) next();
  endtask

  task automatic load0(input logic [4:0] r);
    clr(); id_valid = 1; s0_is_load = 1; s0_wen = 1; s0_waddr = r;
  endtask

  task automatic read0(input logic [4:0] r);
    clr(); id_valid = 1; s0_rs_en = 1; s0_rs_addr = r;
  endtask

  initial begin
    clr();
    rst = 1;
    id_valid = 1; s1_valid = 1;
    #2; check("rst_issue0", issue0, 1'b0);
    check("rst_issue1", issue1, 1'b0);
    check("rst_div_busy", div_busy, 1'b0);
    next(); next();
    rst = 0;
    idle(1);

    // Load-use: two stall cycles
    load0(5); settle(); check("lu_c0_issue", issue0, 1'b1);
    next(); read0(5); settle(); check("lu_c1", issue0, 1'b0);
    next(); settle(); check("lu_c2", issue0, 1'b0);
    next(); settle(); check("lu_c3", issue0, 1'b1);
    idle(3);

    // Load-use with mem_stall in cycle 1
    load0(5); settle(); check("lus_c0", issue0, 1'b1);
    next(); read0(5); mem_stall = 1; settle(); check("lus_c1", issue0, 1'b0);
    next(); mem_stall = 0; settle(); check("lus_c2", issue0, 1'b0);
    next(); settle(); check("lus_c3", issue0, 1'b0);
    next(); settle(); check("lus_c4", issue0, 1'b1);
    idle(3);

    // Intra-pair RAW on $7 blocks slot 1
    clr(); id_valid = 1; s1_valid = 1; s0_wen = 1; s0_waddr = 7; s1_rs_en = 1; s1_rs_addr = 7;
    settle(); check("raw7_issue0", issue0, 1'b1); check("raw7_issue1", issue1, 1'b0);
    // $0 never creates a dependency
    s0_waddr = 0; s1_rs_addr = 0;
    settle(); check("raw0_issue1", issue1, 1'b1);
    // WAW does not block
    s0_waddr = 9; s1_wen = 1; s1_waddr = 9; s1_rs_addr = 3;
    settle(); check("waw_issue1", issue1, 1'b1);
    // Two loads cannot pair
    clr(); id_valid = 1; s1_valid = 1; s0_is_load = 1; s1_is_load = 1;
    settle(); check("ldld_issue0", issue0, 1'b1); check("ldld_issue1", issue1, 1'b0);
    // Slot 1 invalid
    clr(); id_valid = 1; s1_valid = 0;
    settle(); check("s1inv_issue1", issue1, 1'b0);
    // Div in slot 1 never pairs
    s1_valid = 1; s1_is_div = 1;
    settle(); check("s1div_issue1", issue1, 1'b0);
    // Slot-1 scoreboard hazard on a load issued the previous cycle
    next(); load0(4); settle(); check("s1haz_ld", issue0, 1'b1);
    next(); clr(); id_valid = 1; s1_valid = 1; s1_rt_en = 1; s1_rt_addr = 4;
    settle(); check("s1haz_issue0", issue0, 1'b1); check("s1haz_issue1", issue1, 1'b0);
    // id_valid low
    clr(); settle(); check("novalid_issue0", issue0, 1'b0);
    idle(3);

    // Divide occupancy: busy for cycles 1..33, mfhi issues cycle 34
    clr(); id_valid = 1; s0_is_div = 1; s1_valid = 1; s1_hilo_rd = 1;
    settle(); check("div_c0_issue0", issue0, 1'b1); check("div_mfhi_pair", issue1, 1'b0);
    check("div_c0_busy", div_busy, 1'b0);
    for (int c = 1; c <= 33; c++) begin
      next(); clr(); id_valid = 1; s0_hilo_rd = 1;
      if (c == 15) mem_stall = 1;
      settle();
      check($sformatf("div_c%0d_busy", c), div_busy, 1'b1);
      check($sformatf("div_c%0d_issue0", c), issue0, 1'b0);
    end
    next(); clr(); id_valid = 1; s0_hilo_rd = 1;
    settle(); check("div_c34_busy", div_busy, 1'b0); check("div_c34_issue0", issue0, 1'b1);
    idle(2);

    // Flush at cycle 10 abandons the divide and clears the scoreboard
    clr(); id_valid = 1; s0_is_div = 1;
    settle(); check("fl_c0_issue0", issue0, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      next(); clr(); id_valid = 1; s0_hilo_rd = 1;
    end
    next(); load0(6); settle(); check("fl_c9_load", issue0, 1'b1);
    next(); clr(); id_valid = 1; s0_hilo_rd = 1; flush = 1;
    settle(); check("fl_c10_issue0", issue0, 1'b0); check("fl_c10_busy", div_busy, 1'b1);
    next(); clr(); id_valid = 1; s0_hilo_rd = 1; s1_valid = 1; s1_rs_en = 1; s1_rs_addr = 6;
    settle(); check("fl_c11_busy", div_busy, 1'b0);
    check("fl_c11_issue0", issue0, 1'b1); check("fl_c11_issue1", issue1, 1'b1);
    idle(3);

    // Asynchronous reset between edges while $3 pending and divider busy
    clr(); id_valid = 1; s0_is_div = 1; s1_valid = 1; s1_is_load = 1; s1_wen = 1; s1_waddr = 3;
    settle(); check("ar_c0_issue1", issue1, 1'b1);
    next(); read0(3); #1;
    check("ar_pre_busy", div_busy, 1'b1); check("ar_pre_issue0", issue0, 1'b0);
    rst = 1; #1;
    check("ar_rst_busy", div_busy, 1'b0); check("ar_rst_issue0", issue0, 1'b0);
    rst = 0; #1;
    check("ar_rel_issue0", issue0, 1'b1);
    s1_valid = 1; s1_hilo_rd = 1; #0.5;
    check("ar_rel_issue1", issue1, 1'b1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
